// File: rtl/riscv_hazard_ctrl_pkg.sv
// ============================================================================
//  Module      : riscv_hazard_ctrl_pkg
//  Description : Shared encodings and forwarding helper for the hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_hazard_ctrl_pkg;

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_MC_WAIT  = 2'd1;
    localparam logic [1:0] c_MEM_WAIT = 2'd2;

    localparam logic [1:0] c_FWD_RF   = 2'b00;
    localparam logic [1:0] c_FWD_WB   = 2'b01;
    localparam logic [1:0] c_FWD_MEM  = 2'b10;

    // MEM holds the younger result, so it takes priority over WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic [4:0] wb_rd,
        input logic       mem_wr,
        input logic       wb_wr
    );
        if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs))
            return c_FWD_MEM;
        else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs))
            return c_FWD_WB;
        else
            return c_FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_fwd_unit.sv
// ============================================================================
//  Module      : riscv_fwd_unit
//  Description : Combinational EX-stage operand forwarding select.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_fwd_unit
    import riscv_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_EX_rs1_addr,
    input  logic [4:0] i_EX_rs2_addr,
    input  logic [4:0] i_MEM_rd_addr,
    input  logic [4:0] i_WB_rd_addr,
    input  logic       i_MEM_reg_wr,
    input  logic       i_WB_reg_wr,
    output logic [1:0] o_ForwardAE,
    output logic [1:0] o_ForwardBE
);

    assign o_ForwardAE = fwd_sel(i_EX_rs1_addr, i_MEM_rd_addr, i_WB_rd_addr,
                                 i_MEM_reg_wr, i_WB_reg_wr);
    assign o_ForwardBE = fwd_sel(i_EX_rs2_addr, i_MEM_rd_addr, i_WB_rd_addr,
                                 i_MEM_reg_wr, i_WB_reg_wr);

endmodule

`default_nettype wire

// File: rtl/riscv_hazard_ctrl.sv
// ============================================================================
//  Module      : riscv_hazard_ctrl
//  Description : Stall/flush sequencing, forwarding and wait watchdog for the
//                5-stage RV32I pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_hazard_ctrl
    import riscv_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
)(
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [4:0]       i_ID_rs1_addr,
    input  logic [4:0]       i_ID_rs2_addr,
    input  logic [4:0]       i_EX_rs1_addr,
    input  logic [4:0]       i_EX_rs2_addr,
    input  logic [4:0]       i_EX_rd_addr,
    input  logic             i_EX_is_load,
    input  logic             i_EX_pc_src,
    input  logic             i_EX_mc_start,
    input  logic             i_mc_done,
    input  logic [4:0]       i_MEM_rd_addr,
    input  logic [4:0]       i_WB_rd_addr,
    input  logic             i_MEM_reg_wr,
    input  logic             i_WB_reg_wr,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_StallF,
    output logic             o_StallD,
    output logic             o_StallE,
    output logic             o_StallM,
    output logic             o_FlushD,
    output logic             o_FlushE,
    output logic             o_FlushM,
    output logic             o_FlushW,
    output logic [1:0]       o_ForwardAE,
    output logic [1:0]       o_ForwardBE,
    output logic             o_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int                  c_WCNT_W    = $clog2(TIMEOUT);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic                r_err;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_mem_wait;
    logic                w_mc_wait;
    logic                w_lw_stall;
    logic                w_abort;

    riscv_fwd_unit u_fwd (
        .i_EX_rs1_addr (i_EX_rs1_addr),
        .i_EX_rs2_addr (i_EX_rs2_addr),
        .i_MEM_rd_addr (i_MEM_rd_addr),
        .i_WB_rd_addr  (i_WB_rd_addr),
        .i_MEM_reg_wr  (i_MEM_reg_wr),
        .i_WB_reg_wr   (i_WB_reg_wr),
        .o_ForwardAE   (o_ForwardAE),
        .o_ForwardBE   (o_ForwardBE)
    );

    // A memory request cannot be outstanding behind a stalled MC op (MEM is
    // bubbled), so the memory term is only honoured outside MC_WAIT. Leaving
    // MEM_WAIT with the MC op still pending drops straight into the MC stall.
    assign w_mem_wait = i_dmem_req & ~i_dmem_ack & (r_state != c_MC_WAIT);
    assign w_mc_wait  = i_EX_mc_start & ~i_mc_done & ~w_mem_wait;
    assign w_lw_stall = i_EX_is_load & (i_EX_rd_addr != 5'd0) &
                        ((i_EX_rd_addr == i_ID_rs1_addr) |
                         (i_EX_rd_addr == i_ID_rs2_addr));
    assign w_abort    = (r_wait_cnt == c_WCNT_LAST) &
                        (((r_state == c_MEM_WAIT) & w_mem_wait) |
                         ((r_state == c_MC_WAIT)  & w_mc_wait));

    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        o_FlushM = 1'b0;
        o_FlushW = 1'b0;
        if (w_mem_wait) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_StallM = 1'b1;
            o_FlushW = 1'b1;
        end else if (w_mc_wait) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_FlushM = 1'b1;
            o_FlushE = w_abort;
        end else begin
            o_StallF = w_lw_stall & ~i_EX_pc_src;
            o_StallD = w_lw_stall & ~i_EX_pc_src;
            o_FlushD = i_EX_pc_src;
            o_FlushE = i_EX_pc_src | w_lw_stall;
        end
    end

    always_comb begin
        if (w_abort)
            w_next_state = c_RUN;
        else if (w_mem_wait)
            w_next_state = c_MEM_WAIT;
        else if (w_mc_wait)
            w_next_state = c_MC_WAIT;
        else
            w_next_state = c_RUN;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= c_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state != c_RUN) && (w_next_state == r_state))
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (w_abort)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_stall_cnt <= '0;
        else if (o_StallF && (r_stall_cnt != c_CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign o_err       = r_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_riscv_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_riscv_hazard_ctrl
//  Description : Self-checking bench: vector table, corner sequences and a
//                randomized run against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_hazard_ctrl;

    localparam int TO    = 8;
    localparam int CW    = 5;
    localparam int SCMAX = (1 << CW) - 1;

    typedef struct {
        logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
        logic       ex_is_load, pc_src, mc_start, mc_done;
        logic       mem_wr, wb_wr, req, ack;
    } in_t;

    typedef struct {
        in_t        i;
        logic [1:0] fa, fb;
        logic       sf, fd, fe;
    } vec_t;

    logic          clk, rstn;
    logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          ex_is_load, pc_src, mc_start, mc_done, mem_wr, wb_wr, req, ack;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          err;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: kind 0 = flowing, 1 = multi-cycle wait, 2 = memory wait
    int m_kind, m_cnt, m_sc, m_next;
    bit m_err, m_abort;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw;
    int e_fa, e_fb;

    riscv_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_ID_rs1_addr(id_rs1), .i_ID_rs2_addr(id_rs2),
        .i_EX_rs1_addr(ex_rs1), .i_EX_rs2_addr(ex_rs2), .i_EX_rd_addr(ex_rd),
        .i_EX_is_load(ex_is_load), .i_EX_pc_src(pc_src),
        .i_EX_mc_start(mc_start), .i_mc_done(mc_done),
        .i_MEM_rd_addr(mem_rd), .i_WB_rd_addr(wb_rd),
        .i_MEM_reg_wr(mem_wr), .i_WB_reg_wr(wb_wr),
        .i_dmem_req(req), .i_dmem_ack(ack),
        .o_StallF(StallF), .o_StallD(StallD), .o_StallE(StallE), .o_StallM(StallM),
        .o_FlushD(FlushD), .o_FlushE(FlushE), .o_FlushM(FlushM), .o_FlushW(FlushW),
        .o_ForwardAE(ForwardAE), .o_ForwardBE(ForwardBE),
        .o_err(err), .o_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int fwd_model(int rs, int mrd, int wrd, bit mwr, bit wwr);
        if (mwr && mrd != 0 && mrd == rs) return 2;
        if (wwr && wrd != 0 && wrd == rs) return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        m_kind = 0; m_cnt = 0; m_sc = 0; m_err = 0;
    endfunction

    function automatic void model_eval(in_t x);
        bit mem, mc, lw;
        mem = x.req && !x.ack && (m_kind != 1);
        mc  = x.mc_start && !x.mc_done && !mem;
        lw  = x.ex_is_load && x.ex_rd != 0 && (x.ex_rd == x.id_rs1 || x.ex_rd == x.id_rs2);
        m_abort = (m_cnt == TO - 1) && ((m_kind == 2 && mem) || (m_kind == 1 && mc));
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw} = '0;
        e_fa = fwd_model(x.ex_rs1, x.mem_rd, x.wb_rd, x.mem_wr, x.wb_wr);
        e_fb = fwd_model(x.ex_rs2, x.mem_rd, x.wb_rd, x.mem_wr, x.wb_wr);
        if (mem) begin
            e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fw = 1;
        end else if (mc) begin
            e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1; e_fe = m_abort;
        end else begin
            e_sf = lw && !x.pc_src; e_sd = e_sf;
            e_fd = x.pc_src; e_fe = x.pc_src || lw;
        end
        m_next = m_abort ? 0 : (mem ? 2 : (mc ? 1 : 0));
    endfunction

    function automatic void model_update();
        m_cnt  = (m_kind != 0 && m_next == m_kind) ? m_cnt + 1 : 0;
        m_kind = m_next;
        if (m_abort) m_err = 1;
        if (e_sf && m_sc < SCMAX) m_sc++;
    endfunction

    task automatic drive(input in_t x);
        id_rs1 = x.id_rs1; id_rs2 = x.id_rs2; ex_rs1 = x.ex_rs1; ex_rs2 = x.ex_rs2;
        ex_rd = x.ex_rd; mem_rd = x.mem_rd; wb_rd = x.wb_rd;
        ex_is_load = x.ex_is_load; pc_src = x.pc_src; mc_start = x.mc_start;
        mc_done = x.mc_done; mem_wr = x.mem_wr; wb_wr = x.wb_wr; req = x.req; ack = x.ack;
    endtask

    task automatic check_all();
        chk("StallF", StallF, e_sf);  chk("StallD", StallD, e_sd);
        chk("StallE", StallE, e_se);  chk("StallM", StallM, e_sm);
        chk("FlushD", FlushD, e_fd);  chk("FlushE", FlushE, e_fe);
        chk("FlushM", FlushM, e_fm);  chk("FlushW", FlushW, e_fw);
        chk("ForwardAE", ForwardAE, e_fa); chk("ForwardBE", ForwardBE, e_fb);
        chk("err", err, m_err);       chk("stall_cnt", stall_cnt, m_sc);
    endtask

    task automatic apply(input in_t x);
        drive(x);
        model_eval(x);
        #2;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cycle(input in_t x);
        apply(x);
        advance();
    endtask

    vec_t v[10];
    in_t  z, x;
    bit   mc_pend;

    initial begin
        z = '{default: '0};
        for (int k = 0; k < 10; k++) begin
            v[k].i = z; v[k].fa = 0; v[k].fb = 0; v[k].sf = 0; v[k].fd = 0; v[k].fe = 0;
        end
        v[1].i.mem_rd = 7; v[1].i.wb_rd = 7; v[1].i.ex_rs1 = 7;
        v[1].i.mem_wr = 1; v[1].i.wb_wr = 1; v[1].fa = 2'b10;
        v[2].i.mem_wr = 1; v[2].i.wb_wr = 1;
        v[3].i.wb_rd = 3; v[3].i.wb_wr = 1; v[3].i.mem_rd = 3; v[3].i.ex_rs2 = 3; v[3].fb = 2'b01;
        v[4].i.mem_rd = 9; v[4].i.mem_wr = 1; v[4].i.ex_rs1 = 9; v[4].i.ex_rs2 = 9;
        v[4].i.wb_rd = 9; v[4].i.wb_wr = 1; v[4].fa = 2'b10; v[4].fb = 2'b10;
        v[5].i.ex_is_load = 1; v[5].i.ex_rd = 5; v[5].i.id_rs2 = 5;
        v[5].sf = 1; v[5].fe = 1;
        v[6].i.ex_is_load = 1; v[6].i.ex_rd = 5; v[6].i.id_rs2 = 5; v[6].i.pc_src = 1;
        v[6].fd = 1; v[6].fe = 1;
        v[7].i.ex_is_load = 1;
        v[8].i.pc_src = 1; v[8].fd = 1; v[8].fe = 1;
        v[9].i.ex_is_load = 1; v[9].i.ex_rd = 4; v[9].i.id_rs1 = 4; v[9].i.id_rs2 = 1;
        v[9].i.wb_rd = 4; v[9].i.wb_wr = 1; v[9].i.ex_rs2 = 4; v[9].sf = 1; v[9].fe = 1; v[9].fb = 2'b01;

        rstn = 1'b0;
        drive(z);
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        chk("rst_StallF", StallF, 0); chk("rst_FlushE", FlushE, 0);
        chk("rst_FlushW", FlushW, 0); chk("rst_err", err, 0); chk("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Load-use: one stall cycle, counter reads 1 afterwards
        x = z; x.ex_is_load = 1; x.ex_rd = 5; x.id_rs2 = 5;
        apply(x);
        chk("lu_StallF", StallF, 1); chk("lu_StallD", StallD, 1); chk("lu_FlushE", FlushE, 1);
        advance();
        apply(z);
        chk("lu_cnt", stall_cnt, 1); chk("lu_release", StallF, 0);
        advance();

        for (int k = 0; k < 10; k++) begin
            apply(v[k].i);
            chk($sformatf("vec%0d_fa", k), ForwardAE, v[k].fa);
            chk($sformatf("vec%0d_fb", k), ForwardBE, v[k].fb);
            chk($sformatf("vec%0d_sf", k), StallF, v[k].sf);
            chk($sformatf("vec%0d_fd", k), FlushD, v[k].fd);
            chk($sformatf("vec%0d_fe", k), FlushE, v[k].fe);
            advance();
        end
        cycle(z);

        // Multi-cycle op, done after 3 cycles
        x = z; x.mc_start = 1;
        for (int k = 0; k < 3; k++) begin
            apply(x);
            chk("mc_StallE", StallE, 1); chk("mc_FlushM", FlushM, 1); chk("mc_StallM", StallM, 0);
            advance();
        end
        x.mc_done = 1;
        apply(x);
        chk("mc_rel_StallF", StallF, 0); chk("mc_rel_FlushM", FlushM, 0);
        advance();
        cycle(z);

        // Memory wait with a taken branch held throughout
        x = z; x.req = 1; x.pc_src = 1;
        for (int k = 0; k < 4; k++) begin
            apply(x);
            chk("mw_StallM", StallM, 1); chk("mw_FlushW", FlushW, 1);
            chk("mw_FlushD", FlushD, 0); chk("mw_FlushE", FlushE, 0);
            advance();
        end
        x.ack = 1;
        apply(x);
        chk("mw_rel_StallF", StallF, 0); chk("mw_rel_FlushD", FlushD, 1);
        advance();
        cycle(z);

        // Watchdog: entry cycle plus TO wait-state cycles, abort on the last
        x = z; x.mc_start = 1;
        for (int k = 0; k <= TO; k++) begin
            apply(x);
            chk("wd_err_pre", err, 0);
            chk("wd_FlushE", FlushE, (k == TO) ? 1 : 0);
            advance();
        end
        apply(z);
        chk("wd_err", err, 1); chk("wd_run_StallF", StallF, 0);
        advance();

        // Asynchronous reset in the middle of a memory wait
        x = z; x.req = 1;
        cycle(x); cycle(x); cycle(x);
        #2;
        rstn = 1'b0;
        drive(z);
        #1;
        chk("arst_err", err, 0); chk("arst_cnt", stall_cnt, 0);
        chk("arst_StallF", StallF, 0); chk("arst_FlushW", FlushW, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < TO + 3; k++) cycle(x);
        cycle(z);

        // Randomized traffic against the model
        mc_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            x = z;
            x.id_rs1 = 5'($urandom_range(0, 3)); x.id_rs2 = 5'($urandom_range(0, 3));
            x.ex_rs1 = 5'($urandom_range(0, 3)); x.ex_rs2 = 5'($urandom_range(0, 3));
            x.ex_rd  = 5'($urandom_range(0, 3)); x.mem_rd = 5'($urandom_range(0, 3));
            x.wb_rd  = 5'($urandom_range(0, 3));
            x.mem_wr = 1'($urandom_range(0, 1)); x.wb_wr = 1'($urandom_range(0, 1));
            x.pc_src = ($urandom_range(0, 4) == 0);
            x.req    = ($urandom_range(0, 3) == 0);
            x.ack    = ($urandom_range(0, 3) == 0);
            if (!mc_pend) mc_pend = ($urandom_range(0, 5) == 0);
            x.mc_start = mc_pend;
            x.mc_done  = mc_pend && ($urandom_range(0, 4) == 0);
            x.ex_is_load = !mc_pend && ($urandom_range(0, 2) == 0);
            cycle(x);
            if (x.mc_done) mc_pend = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
